// File: rtl/zap_wb_merger_n.sv
// N-master Wishbone B3 merger: fixed-priority or round-robin arbitration with a
// locked grant per cycle and one idle turnaround cycle between grants.
module zap_wb_merger_n #(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = 0,
  localparam int PTR_W      = $clog2(NUM_MASTERS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_wb_wen,
  input  logic [4*NUM_MASTERS-1:0]  i_m_wb_sel,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_dat,
  input  logic [32*NUM_MASTERS-1:0] i_m_wb_adr,
  input  logic [3*NUM_MASTERS-1:0]  i_m_wb_cti,
  output logic [NUM_MASTERS-1:0]    o_m_wb_ack,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_wen,
  output logic [3:0]                o_wb_sel,
  output logic [31:0]               o_wb_dat,
  output logic [31:0]               o_wb_adr,
  output logic [2:0]                o_wb_cti,
  input  logic                      i_wb_ack,
  output logic [NUM_MASTERS-1:0]    o_grant
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       gidx_q, gidx_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   wb_cyc_q, wb_cyc_d;
  logic                   wb_stb_q, wb_stb_d;
  logic                   wb_wen_q, wb_wen_d;
  logic [3:0]             wb_sel_q, wb_sel_d;
  logic [31:0]            wb_dat_q, wb_dat_d;
  logic [31:0]            wb_adr_q, wb_adr_d;
  logic [2:0]             wb_cti_q, wb_cti_d;

  logic [PTR_W-1:0]       base_s;
  logic [PTR_W:0]         sum_s;
  logic [PTR_W-1:0]       win_idx_s;
  logic                   found_s;
  logic [NUM_MASTERS-1:0] win_oh_s;
  logic [NUM_MASTERS-1:0] sel_oh_s;
  logic                   fld_stb_s, fld_wen_s;
  logic [3:0]             fld_sel_s;
  logic [31:0]            fld_dat_s, fld_adr_s;
  logic [2:0]             fld_cti_s;

  // Winner search starts at the RR pointer (or 0 for fixed priority) and wraps modulo N.
  always_comb begin
    base_s    = (ARB_MODE == 1) ? rr_ptr_q : {PTR_W{1'b0}};
    sum_s     = {(PTR_W+1){1'b0}};
    win_idx_s = {PTR_W{1'b0}};
    found_s   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum_s = {1'b0, base_s} + (PTR_W+1)'(i);
      if (sum_s >= (PTR_W+1)'(NUM_MASTERS)) begin
        sum_s = sum_s - (PTR_W+1)'(NUM_MASTERS);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && i_m_wb_cyc[sum_s[PTR_W-1:0]]) begin
        found_s   = 1'b1;
        win_idx_s = sum_s[PTR_W-1:0];
      end else begin
        found_s   = found_s;
      end
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      win_oh_s[k] = found_s && (win_idx_s == PTR_W'(k));
    end
  end

  // AND-OR field mux driven by the new winner in IDLE or the locked grant in BUSY.
  always_comb begin
    sel_oh_s  = (state_q == ST_BUSY) ? grant_q : win_oh_s;
    fld_stb_s = 1'b0;
    fld_wen_s = 1'b0;
    fld_sel_s = 4'h0;
    fld_dat_s = 32'h0;
    fld_adr_s = 32'h0;
    fld_cti_s = 3'b000;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      fld_stb_s = fld_stb_s | (i_m_wb_stb[k] & sel_oh_s[k]);
      fld_wen_s = fld_wen_s | (i_m_wb_wen[k] & sel_oh_s[k]);
      fld_sel_s = fld_sel_s | (i_m_wb_sel[4*k +: 4]   & {4{sel_oh_s[k]}});
      fld_dat_s = fld_dat_s | (i_m_wb_dat[32*k +: 32] & {32{sel_oh_s[k]}});
      fld_adr_s = fld_adr_s | (i_m_wb_adr[32*k +: 32] & {32{sel_oh_s[k]}});
      fld_cti_s = fld_cti_s | (i_m_wb_cti[3*k +: 3]   & {3{sel_oh_s[k]}});
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    wb_cyc_d = 1'b0;
    wb_stb_d = 1'b0;
    wb_wen_d = wb_wen_q;
    wb_sel_d = wb_sel_q;
    wb_dat_d = wb_dat_q;
    wb_adr_d = wb_adr_q;
    wb_cti_d = wb_cti_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d  = ST_BUSY;
          grant_d  = win_oh_s;
          gidx_d   = win_idx_s;
          wb_cyc_d = 1'b1;
          wb_stb_d = fld_stb_s;
          wb_wen_d = fld_wen_s;
          wb_sel_d = fld_sel_s;
          wb_dat_d = fld_dat_s;
          wb_adr_d = fld_adr_s;
          wb_cti_d = fld_cti_s;
        end else begin
          state_d  = ST_IDLE;
          grant_d  = {NUM_MASTERS{1'b0}};
        end
      end
      ST_BUSY: begin
        if (|(i_m_wb_cyc & grant_q)) begin
          wb_cyc_d = 1'b1;
          wb_stb_d = fld_stb_s;
          wb_wen_d = fld_wen_s;
          wb_sel_d = fld_sel_s;
          wb_dat_d = fld_dat_s;
          wb_adr_d = fld_adr_s;
          wb_cti_d = fld_cti_s;
        end else begin
          // Release: the next arbitration happens from IDLE, forcing a cyc-low cycle.
          state_d  = ST_IDLE;
          grant_d  = {NUM_MASTERS{1'b0}};
          rr_ptr_d = (gidx_q == PTR_W'(NUM_MASTERS-1)) ? {PTR_W{1'b0}} : gidx_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_MASTERS{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= {NUM_MASTERS{1'b0}};
      gidx_q   <= {PTR_W{1'b0}};
      rr_ptr_q <= {PTR_W{1'b0}};
      wb_cyc_q <= 1'b0;
      wb_stb_q <= 1'b0;
      wb_wen_q <= 1'b0;
      wb_sel_q <= 4'h0;
      wb_dat_q <= 32'h0;
      wb_adr_q <= 32'h0;
      wb_cti_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      wb_cyc_q <= wb_cyc_d;
      wb_stb_q <= wb_stb_d;
      wb_wen_q <= wb_wen_d;
      wb_sel_q <= wb_sel_d;
      wb_dat_q <= wb_dat_d;
      wb_adr_q <= wb_adr_d;
      wb_cti_q <= wb_cti_d;
    end
  end

  // Downstream ack is routed only to the granted master, and only while BUSY.
  always_comb begin
    if (state_q == ST_BUSY) begin
      o_m_wb_ack = grant_q & {NUM_MASTERS{i_wb_ack}};
    end else begin
      o_m_wb_ack = {NUM_MASTERS{1'b0}};
    end
  end

  assign o_wb_cyc = wb_cyc_q;
  assign o_wb_stb = wb_stb_q;
  assign o_wb_wen = wb_wen_q;
  assign o_wb_sel = wb_sel_q;
  assign o_wb_dat = wb_dat_q;
  assign o_wb_adr = wb_adr_q;
  assign o_wb_cti = wb_cti_q;
  assign o_grant  = grant_q;

endmodule

// File: tb/tb_zap_wb_merger_n.sv
// Directed bench for zap_wb_merger_n: fixed priority (N=4), round-robin (N=3)
// and round-robin pointer wrap (N=8), with hand-computed expectations.
module tb_zap_wb_merger_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;

  // N=4 fixed priority instance
  logic [3:0] c4, s4, w4, a4o, g4;
  logic [15:0] sel4;
  logic [127:0] d4, ad4;
  logic [11:0] t4;
  logic ack4, o4_cyc, o4_stb, o4_wen;
  logic [3:0] o4_sel;
  logic [31:0] o4_dat, o4_adr;
  logic [2:0] o4_cti;

  // N=3 round-robin instance
  logic [2:0] c3, s3, w3, a3o, g3;
  logic [11:0] sel3;
  logic [95:0] d3, ad3;
  logic [8:0] t3;
  logic ack3, o3_cyc, o3_stb, o3_wen;
  logic [3:0] o3_sel;
  logic [31:0] o3_dat, o3_adr;
  logic [2:0] o3_cti;

  // N=8 round-robin instance
  logic [7:0] c8, s8, w8, a8o, g8;
  logic [31:0] sel8;
  logic [255:0] d8, ad8;
  logic [23:0] t8;
  logic ack8, o8_cyc, o8_stb, o8_wen;
  logic [3:0] o8_sel;
  logic [31:0] o8_dat, o8_adr;
  logic [2:0] o8_cti;

  zap_wb_merger_n #(.NUM_MASTERS(4), .ARB_MODE(0)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_m_wb_cyc(c4), .i_m_wb_stb(s4), .i_m_wb_wen(w4),
    .i_m_wb_sel(sel4), .i_m_wb_dat(d4), .i_m_wb_adr(ad4), .i_m_wb_cti(t4), .o_m_wb_ack(a4o),
    .o_wb_cyc(o4_cyc), .o_wb_stb(o4_stb), .o_wb_wen(o4_wen), .o_wb_sel(o4_sel),
    .o_wb_dat(o4_dat), .o_wb_adr(o4_adr), .o_wb_cti(o4_cti), .i_wb_ack(ack4), .o_grant(g4));

  zap_wb_merger_n #(.NUM_MASTERS(3), .ARB_MODE(1)) u_dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_m_wb_cyc(c3), .i_m_wb_stb(s3), .i_m_wb_wen(w3),
    .i_m_wb_sel(sel3), .i_m_wb_dat(d3), .i_m_wb_adr(ad3), .i_m_wb_cti(t3), .o_m_wb_ack(a3o),
    .o_wb_cyc(o3_cyc), .o_wb_stb(o3_stb), .o_wb_wen(o3_wen), .o_wb_sel(o3_sel),
    .o_wb_dat(o3_dat), .o_wb_adr(o3_adr), .o_wb_cti(o3_cti), .i_wb_ack(ack3), .o_grant(g3));

  zap_wb_merger_n #(.NUM_MASTERS(8), .ARB_MODE(1)) u_dut8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_m_wb_cyc(c8), .i_m_wb_stb(s8), .i_m_wb_wen(w8),
    .i_m_wb_sel(sel8), .i_m_wb_dat(d8), .i_m_wb_adr(ad8), .i_m_wb_cti(t8), .o_m_wb_ack(a8o),
    .o_wb_cyc(o8_cyc), .o_wb_stb(o8_stb), .o_wb_wen(o8_wen), .o_wb_sel(o8_sel),
    .o_wb_dat(o8_dat), .o_wb_adr(o8_adr), .o_wb_cti(o8_cti), .i_wb_ack(ack8), .o_grant(g8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input int k, input logic cyc, input logic stb, input logic wen,
                      input logic [3:0] sel, input logic [31:0] dat, input logic [31:0] adr,
                      input logic [2:0] cti);
    c4[k] = cyc; s4[k] = stb; w4[k] = wen;
    sel4[4*k +: 4] = sel; d4[32*k +: 32] = dat; ad4[32*k +: 32] = adr; t4[3*k +: 3] = cti;
  endtask

  task automatic test_reset();
    c4 = '0; s4 = '0; w4 = '0; sel4 = '0; d4 = '0; ad4 = '0; t4 = '0; ack4 = 1'b0;
    c3 = '0; s3 = '0; w3 = '0; sel3 = '0; d3 = '0; ad3 = '0; t3 = '0; ack3 = 1'b0;
    c8 = '0; s8 = '0; w8 = '0; sel8 = '0; d8 = '0; ad8 = '0; t8 = '0; ack8 = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (o4_cyc !== 1'b0) begin n_err++; $display("FAIL reset_cyc4: got %b want 0", o4_cyc); end
    n_vec++; if (g4 !== 4'b0000) begin n_err++; $display("FAIL reset_grant4: got %b want 0000", g4); end
    n_vec++; if (o4_adr !== 32'h0) begin n_err++; $display("FAIL reset_adr4: got %h want 0", o4_adr); end
    n_vec++; if (g3 !== 3'b000 || g8 !== 8'h00) begin n_err++; $display("FAIL reset_grant38: got %b %b want 0 0", g3, g8); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (o4_cyc !== 1'b0 || g4 !== 4'b0000) begin n_err++; $display("FAIL idle_no_req: got cyc=%b grant=%b want 0 0000", o4_cyc, g4); end
  endtask

  task automatic test_fixed_priority();
    set4(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_1000, 3'b000);
    set4(3, 1'b1, 1'b1, 1'b0, 4'h3, 32'h3333_3333, 32'h0000_3000, 3'b000);
    tick();
    n_vec++; if (g4 !== 4'b0010) begin n_err++; $display("FAIL fp_grant1: got %b want 0010", g4); end
    n_vec++; if (o4_adr !== 32'h0000_1000) begin n_err++; $display("FAIL fp_adr1: got %h want 00001000", o4_adr); end
    n_vec++; if (o4_dat !== 32'hDEAD_BEEF || o4_wen !== 1'b1 || o4_cyc !== 1'b1) begin
      n_err++; $display("FAIL fp_fields1: got dat=%h wen=%b cyc=%b want deadbeef 1 1", o4_dat, o4_wen, o4_cyc); end
    tick();
    n_vec++; if (g4 !== 4'b0010) begin n_err++; $display("FAIL fp_hold1: got %b want 0010", g4); end
    c4[1] = 1'b0;
    tick();
    n_vec++; if (o4_cyc !== 1'b0 || g4 !== 4'b0000) begin n_err++; $display("FAIL fp_release1: got cyc=%b grant=%b want 0 0000", o4_cyc, g4); end
    tick();
    n_vec++; if (g4 !== 4'b1000 || o4_adr !== 32'h0000_3000 || o4_sel !== 4'h3) begin
      n_err++; $display("FAIL fp_grant3: got grant=%b adr=%h sel=%h want 1000 00003000 3", g4, o4_adr, o4_sel); end
    c4[3] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_burst_lock();
    int acks0;
    int acks1;
    acks0 = 0; acks1 = 0;
    set4(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_2000, 3'b010);
    set4(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_1111, 32'h0000_1100, 3'b000);
    tick();
    n_vec++; if (g4 !== 4'b0001) begin n_err++; $display("FAIL burst_grant0: got %b want 0001", g4); end
    for (int b = 0; b < 8; b++) begin
      ad4[31:0] = 32'h0000_2000 + 32'(4*b);
      t4[2:0] = (b == 7) ? 3'b111 : 3'b010;
      ack4 = 1'b1;
      #1;
      acks0 += int'(a4o[0]);
      acks1 += int'(a4o[1]);
      n_vec++; if (a4o !== 4'b0001) begin n_err++; $display("FAIL burst_ack_beat%0d: got %b want 0001", b, a4o); end
      tick();
      n_vec++; if (o4_adr !== 32'h0000_2000 + 32'(4*b) || o4_cti !== t4[2:0]) begin
        n_err++; $display("FAIL burst_fwd_beat%0d: got adr=%h cti=%b want %h %b", b, o4_adr, o4_cti, 32'h0000_2000 + 32'(4*b), t4[2:0]); end
    end
    ack4 = 1'b0;
    c4[0] = 1'b0;
    tick();
    n_vec++; if (g4 !== 4'b0000) begin n_err++; $display("FAIL burst_release: got %b want 0000", g4); end
    n_vec++; if (acks0 !== 8 || acks1 !== 0) begin n_err++; $display("FAIL burst_ack_count: got m0=%0d m1=%0d want 8 0", acks0, acks1); end
    tick();
    n_vec++; if (g4 !== 4'b0010 || o4_adr !== 32'h0000_1100) begin
      n_err++; $display("FAIL burst_next_grant: got grant=%b adr=%h want 0010 00001100", g4, o4_adr); end
    c4[1] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ack_isolation();
    ack4 = 1'b1;
    #1;
    n_vec++; if (a4o !== 4'b0000) begin n_err++; $display("FAIL ack_idle: got %b want 0000", a4o); end
    ack4 = 1'b0;
    set4(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_2222, 32'h0000_2200, 3'b000);
    tick();
    n_vec++; if (g4 !== 4'b0100) begin n_err++; $display("FAIL ack_grant2: got %b want 0100", g4); end
    ack4 = 1'b1;
    #1;
    n_vec++; if (a4o !== 4'b0100) begin n_err++; $display("FAIL ack_busy_hi: got %b want 0100", a4o); end
    ack4 = 1'b0;
    #1;
    n_vec++; if (a4o !== 4'b0000) begin n_err++; $display("FAIL ack_busy_lo: got %b want 0000", a4o); end
    c4[2] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_burst();
    set4(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_4000, 3'b010);
    tick();
    n_vec++; if (g4 !== 4'b0010) begin n_err++; $display("FAIL rstb_grant1: got %b want 0010", g4); end
    for (int b = 1; b < 6; b++) begin
      ad4[63:32] = 32'h0000_4000 + 32'(4*b);
      ack4 = 1'b1;
      tick();
    end
    ack4 = 1'b0;
    rst_n = 1'b0;
    tick();
    n_vec++; if (o4_cyc !== 1'b0 || g4 !== 4'b0000 || o4_adr !== 32'h0) begin
      n_err++; $display("FAIL rstb_drop: got cyc=%b grant=%b adr=%h want 0 0000 0", o4_cyc, g4, o4_adr); end
    rst_n = 1'b1;
    set4(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 3'b000);
    tick(); tick();
    n_vec++; if (o4_cyc !== 1'b0 || g4 !== 4'b0000) begin
      n_err++; $display("FAIL rstb_idle: got cyc=%b grant=%b want 0 0000", o4_cyc, g4); end
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] exp_oh;
    s3 = 3'b111;
    for (int k = 0; k < 3; k++) ad3[32*k +: 32] = 32'h0000_0100 * 32'(k + 1);
    c3 = 3'b111;
    for (int i = 0; i < 6; i++) begin
      exp_oh = 3'b001;
      exp_oh = exp_oh << exp_seq[i];
      tick();
      n_vec++; if (g3 !== exp_oh || o3_cyc !== 1'b1 || o3_adr !== 32'h0000_0100 * 32'(exp_seq[i] + 1)) begin
        n_err++; $display("FAIL rr_grant%0d: got grant=%b cyc=%b adr=%h want %b 1 %h", i, g3, o3_cyc, o3_adr, exp_oh, 32'h0000_0100 * 32'(exp_seq[i] + 1)); end
      c3[exp_seq[i]] = 1'b0;
      tick();
      n_vec++; if (o3_cyc !== 1'b0 || g3 !== 3'b000) begin
        n_err++; $display("FAIL rr_turnaround%0d: got cyc=%b grant=%b want 0 000", i, o3_cyc, g3); end
      c3[exp_seq[i]] = 1'b1;
    end
    c3 = 3'b000;
    tick(); tick();
  endtask

  task automatic test_wrap();
    s8 = 8'hFF;
    ad8[255:224] = 32'h0000_7000;
    ad8[31:0]    = 32'h0000_0A00;
    ad8[223:192] = 32'h0000_6000;
    c8[7] = 1'b1;
    tick();
    n_vec++; if (g8 !== 8'h80) begin n_err++; $display("FAIL wrap_grant7: got %b want 10000000", g8); end
    c8[7] = 1'b0;
    tick();
    n_vec++; if (g8 !== 8'h00 || o8_cyc !== 1'b0) begin n_err++; $display("FAIL wrap_release7: got grant=%b cyc=%b want 0 0", g8, o8_cyc); end
    c8[0] = 1'b1;
    c8[6] = 1'b1;
    tick();
    n_vec++; if (g8 !== 8'h01 || o8_adr !== 32'h0000_0A00) begin
      n_err++; $display("FAIL wrap_grant0: got grant=%b adr=%h want 00000001 00000a00", g8, o8_adr); end
    c8[0] = 1'b0;
    tick();
    c8[0] = 1'b1;
    tick();
    n_vec++; if (g8 !== 8'h40 || o8_adr !== 32'h0000_6000) begin
      n_err++; $display("FAIL wrap_grant6: got grant=%b adr=%h want 01000000 00006000", g8, o8_adr); end
    c8 = 8'h00;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_burst_lock();
    test_ack_isolation();
    test_round_robin();
    test_wrap();
    test_reset_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zap_wb_merger_n.md
Name: zap_wb_merger_n

Overview:
- N-master Wishbone B3 merger.
- Generalised successor to the two-master code/data merger.
- Sits between the N cache/MMU requestors (I-cache, D-cache, table walker, DMA) and the store-buffer/bus adapter.
- Adds parametrised master count, fixed-priority or round-robin arbitration, and a bus-turnaround guarantee between grants.

Parameters:
NUM_MASTERS, 2, number of requesting masters; legal range 2..8.
ARB_MODE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin.
PTR_W, $clog2(NUM_MASTERS), width of grant index and RR pointer. Derived; never overridden.

Ports:
i_clk  in  1  single clock, rising edge.
i_reset_n  in  1  reset; synchronous, active-low.
i_m_wb_cyc  in  NUM_MASTERS  per-master cyc (next-cycle value, cache _nxt style).
i_m_wb_stb  in  NUM_MASTERS  per-master stb.
i_m_wb_wen  in  NUM_MASTERS  per-master write enable.
i_m_wb_sel  in  4*NUM_MASTERS  byte selects; master k at [4k+3:4k].
i_m_wb_dat  in  32*NUM_MASTERS  write data; master k at [32k+31:32k].
i_m_wb_adr  in  32*NUM_MASTERS  address, same packing as data.
i_m_wb_cti  in  3*NUM_MASTERS  cycle type identifier.
o_m_wb_ack  out  NUM_MASTERS  per-master ack.
o_wb_cyc  out  1  registered merged cyc.
o_wb_stb  out  1  registered merged stb.
o_wb_wen  out  1  registered merged write enable.
o_wb_sel  out  4  registered merged byte selects.
o_wb_dat  out  32  registered merged write data.
o_wb_adr  out  32  registered merged address.
o_wb_cti  out  3  registered merged cycle type.
i_wb_ack  in  1  downstream ack.
o_grant  out  NUM_MASTERS  one-hot current grant; 0 when idle.

Behaviour:
- Reset (i_reset_n low at a rising edge):
  - All o_wb_* = 0, o_grant = 0, RR pointer = 0, state = IDLE.
  - Any in-flight transfer is dropped; o_wb_cyc is 0 the cycle after reset is sampled.
- States: IDLE, BUSY.
- IDLE:
  - o_wb_cyc = o_wb_stb = 0; o_m_wb_ack = 0.
  - If any i_m_wb_cyc is set: select winner w, register grant = w, and register master w's fields into o_wb_*. Go to BUSY.
  - o_wb_cyc rises one cycle after the winner's cyc is first sampled.
  - If no i_m_wb_cyc is set: stay in IDLE.
- Winner selection:
  - ARB_MODE 0: lowest requesting index.
  - ARB_MODE 1: first requesting index at or after the RR pointer, modulo NUM_MASTERS.
- BUSY:
  - Each cycle, o_wb_* <= granted master's fields. Other masters are ignored.
  - o_m_wb_ack[g] = i_wb_ack (combinational). All other ack bits are 0.
  - Grant stays locked while granted i_m_wb_cyc = 1, including across burst beats (cti 010) and between stb pulses.
- Release:
  - When granted i_m_wb_cyc = 0 is sampled: o_wb_cyc/stb <= 0, o_grant <= 0, go to IDLE.
  - RR pointer <= (g+1) mod NUM_MASTERS. The wrap from NUM_MASTERS-1 goes to 0.
  - Arbitration resumes the following cycle. This guarantees at least one cyc-low turnaround cycle between any two grants.
- Simultaneous events:
  - A new request arriving in the same cycle as a release is not considered until IDLE.
  - A request that rises and falls while another master holds the bus is lost. Masters must hold cyc until acked.
- i_wb_ack while IDLE is ignored and is not forwarded.
- o_grant is always one-hot or zero; it is never multi-hot.
- All outputs are registered except o_m_wb_ack.

Test Plan:
- Reset:
  - Stimulus: assert i_reset_n=0 while master 1 is BUSY with a 16-beat burst.
  - Required: next cycle o_wb_cyc=0 and o_grant=0. After release, an all-zero request keeps IDLE.
- Fixed priority (ARB_MODE 0, N=4):
  - Stimulus: masters 1 and 3 raise cyc in the same cycle.
  - Required: o_grant=4'b0010 one cycle later and o_wb_adr = master 1 address (0x0000_1000). Master 3 is granted only after master 1 drops cyc plus one idle cycle.
- Round-robin fairness (ARB_MODE 1, N=3):
  - Stimulus: all three masters request continuously, each 1-beat cycle.
  - Required: grant sequence 0,1,2,0,1,2 with o_wb_cyc low exactly one cycle between grants.
- Burst lock:
  - Stimulus: master 0 issues an 8-beat cti=010 burst ending with cti=111 while master 1 requests.
  - Required: all 8 acks go to o_m_wb_ack[0]; o_m_wb_ack[1]=0 throughout; master 1 is granted afterwards.
- Ack isolation:
  - Stimulus: drive i_wb_ack=1 in IDLE.
  - Required: o_m_wb_ack=0. In BUSY with g=2, only o_m_wb_ack[2] mirrors i_wb_ack.
- Wrap-around (ARB_MODE 1, N=8):
  - Stimulus: master 7 finishes its cycle, then masters 0 and 6 request.
  - Required: RR pointer=0, so master 0 is granted first.
